writeback_unit: RTL

//   Parametrised writeback stage: accepts one decoded instruction per cycle (valid/ready), selects
//   the writeback value (ALU result, link address or extracted/extended load data) and drives the

---
 rtl/writeback_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: picks ALU result, link address or extracted load data and drives the regfile port.
// Latency: non-loads 1 cycle after accept; loads 1 cycle after the rd_valid edge. Optional WB_RETIRE_CNT_EN.
// Backpressure: in_ready is low only while a load waits for memory data.
module writeback_unit #(
    parameter int XLEN   = 32,
    parameter int ILEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   IR,
    input  logic [XLEN-1:0]   PC,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   RD,
    input  logic              rd_valid,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_err,
    output logic [CNT_W-1:0]  retired
);
    localparam int OFFW = $clog2(XLEN / 8);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    state_t      r_state;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic [2:0]  r_a3;

    logic [6:0]      w_op;
    logic [4:0]      w_rd;
    logic            w_accept;
    logic            w_ld_done;
    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_bad;
    logic            w_unused;

    assign w_op      = IR[6:0];
    assign w_rd      = IR[11:7];
    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = in_valid & in_ready;
    assign w_ld_done = (r_state == S_WAIT_MEM) & rd_valid;
    assign w_sh      = RD >> {r_a3[OFFW-1:0], 3'b000};
    assign w_unused  = &{1'b0, IR[ILEN-1:15], A[XLEN-1:3]};

    // The selected lane is shifted down to bit 0 first, so every size extends from the bottom.
    always_comb begin
        w_ld_data = '0;
        w_ld_bad  = 1'b0;
        case (r_f3)
            3'd0: w_ld_data = XLEN'($signed(w_sh[7:0]));
            3'd1: begin
                w_ld_data = XLEN'($signed(w_sh[15:0]));
                w_ld_bad  = r_a3[0];
            end
            3'd2: begin
                w_ld_data = XLEN'($signed(w_sh[31:0]));
                w_ld_bad  = (r_a3[1:0] != 2'b00);
            end
            3'd3: begin
                w_ld_data = w_sh;
                w_ld_bad  = (XLEN != 64) || (r_a3 != 3'b000);
            end
            3'd4: w_ld_data = XLEN'(w_sh[7:0]);
            3'd5: begin
                w_ld_data = XLEN'(w_sh[15:0]);
                w_ld_bad  = r_a3[0];
            end
            3'd6: begin
                w_ld_data = XLEN'(w_sh[31:0]);
                w_ld_bad  = (XLEN != 64) || (r_a3[1:0] != 2'b00);
            end
            default: w_ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_f3    <= '0;
            r_rd    <= '0;
            r_a3    <= '0;
            wb_en   <= 1'b0;
            wb_err  <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            wb_en  <= 1'b0;
            wb_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_f3 <= IR[14:12];
                        r_rd <= w_rd;
                        r_a3 <= A[2:0];
                        if (w_op == OP_LOAD) begin
                            r_state <= S_WAIT_MEM;
                        end else if (w_op == OP_STORE || w_op == OP_BRANCH) begin
                            wb_addr <= '0;
                            wb_data <= '0;
                        end else begin
                            wb_en   <= (w_rd != 5'd0);
                            wb_addr <= REG_AW'(w_rd);
                            wb_data <= (w_op == OP_JAL || w_op == OP_JALR) ? PC + XLEN'(4) : A;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (rd_valid) begin
                        r_state <= S_IDLE;
                        if (w_ld_bad) begin
                            wb_err <= 1'b1;
                        end else begin
                            wb_en   <= (r_rd != 5'd0);
                            wb_addr <= REG_AW'(r_rd);
                            wb_data <= w_ld_data;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    assign w_retire = (w_accept & (w_op != OP_LOAD)) | (w_ld_done & ~w_ld_bad);
    assign retired  = r_retired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end
`else
    assign retired = '0;
`endif

endmodule
